// File: rtl/div_unit_if.sv
// Request/result bundle between the control unit and the divider.
// master = control unit side, slave = divider side.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             divControl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output divControl, a, b,
        input  busy, done, div0, hi, lo
    );

    modport slave (
        input  divControl, a, b,
        output busy, done, div0, hi, lo
    );
endinterface

// File: rtl/div_unit.sv
// Signed restoring divider, one quotient bit per cycle, MIPS DIV semantics:
// lo = quotient, hi = remainder (sign of remainder follows the dividend).
//
// state | meaning
// IDLE  | waiting for divControl; b == 0 raises div0 and stays here
// RUN   | WIDTH restoring iterations on operand magnitudes
// FIX   | apply signs, write hi/lo, pulse done
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic     clk,
    input  logic     reset,
    div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] dvd, divisor, rem;
    logic [WIDTH-1:0] hi_r, lo_r;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   trial;
    logic             sign_q, sign_r;
    logic             done_r, div0_r;
    logic             start, zero_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        zero_req  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.divControl) begin
                    if (bus.b == '0) begin
                        zero_req = 1'b1;
                    end else begin
                        start     = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            RUN:     if (count == CNT_W'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Magnitude of the most negative value wraps to itself and is read as unsigned.
    assign a_abs = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign b_abs = bus.b[WIDTH-1] ? -bus.b : bus.b;

    // rem < divisor <= 2^(WIDTH-1), so the shifted remainder fits and trial[WIDTH] is its sign.
    assign trial = {rem, dvd[WIDTH-1]} - {1'b0, divisor};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            dvd     <= '0;
            divisor <= '0;
            rem     <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
            done_r  <= 1'b0;
            div0_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            div0_r <= zero_req;
            if (start) begin
                dvd     <= a_abs;
                divisor <= b_abs;
                rem     <= '0;
                sign_q  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                sign_r  <= bus.a[WIDTH-1];
                count   <= '0;
            end else if (state == RUN) begin
                rem   <= trial[WIDTH] ? {rem[WIDTH-2:0], dvd[WIDTH-1]} : trial[WIDTH-1:0];
                dvd   <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
                count <= count + CNT_W'(1);
            end else if (state == FIX) begin
                lo_r   <= sign_q ? -dvd : dvd;
                hi_r   <= sign_r ? -rem : rem;
                done_r <= 1'b1;
            end
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.div0 = div0_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a transaction-level model checked every cycle
// plus hand-computed quotient/remainder literals for each vector.
module tb_div_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    div_unit_if #(.WIDTH(32)) dif ();

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    // Model: a request takes 33 cycles, then results land with a done pulse.
    int          m_cnt  = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_div0 = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

    always @(posedge clk or negedge reset) begin
        longint ad, bd, q, r;
        if (!reset) begin
            m_cnt = 0; m_busy = 0; m_done = 0; m_div0 = 0; m_hi = 0; m_lo = 0;
        end else begin
            m_done = 0;
            m_div0 = 0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1;
                end
            end else if (dif.divControl) begin
                if (dif.b == 0) begin
                    m_div0 = 1;
                end else begin
                    ad = longint'($signed(dif.a));
                    bd = longint'($signed(dif.b));
                    q = ad / bd;
                    r = ad % bd;
                    p_lo = q[31:0];
                    p_hi = r[31:0];
                    m_cnt = 33;
                end
            end
            m_busy = (m_cnt > 0);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            check("busy", 32'(dif.busy), 32'(m_busy));
            check("done", 32'(dif.done), 32'(m_done));
            check("div0", 32'(dif.div0), 32'(m_div0));
            check("hi",   dif.hi, m_hi);
            check("lo",   dif.lo, m_lo);
        end
    end

    // Returns at the negedge just after the start edge; operands are then scrambled.
    task automatic start(input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        dif.divControl = 1'b1;
        dif.a = av;
        dif.b = bv;
        @(negedge clk);
        dif.divControl = 1'b0;
        dif.a = $urandom;
        dif.b = $urandom;
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dif.done) begin
                ok = 1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: no done within 40 cycles at %0t", $time);
    endtask

    task automatic run_div(input logic [31:0] av, input logic [31:0] bv,
                           input logic [31:0] q, input logic [31:0] r);
        bit ok;
        start(av, bv);
        wait_done(ok);
        if (ok) begin
            check("lit_lo", dif.lo, q);
            check("lit_hi", dif.hi, r);
        end
    endtask

    initial begin
        bit ok;
        int n;
        dif.divControl = 1'b0;
        dif.a = '0;
        dif.b = '0;
        #12;
        check("rst_busy", 32'(dif.busy), 32'h0);
        check("rst_done", 32'(dif.done), 32'h0);
        check("rst_hi", dif.hi, 32'h0);
        check("rst_lo", dif.lo, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // 7/2 with busy-length and done-width checks
        start(32'd7, 32'd2);
        n = 0;
        while (dif.busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(n), 32'd33);
        check("done_pulse", 32'(dif.done), 32'h1);
        check("lit_lo", dif.lo, 32'd3);
        check("lit_hi", dif.hi, 32'd1);
        @(negedge clk);
        check("done_width", 32'(dif.done), 32'h0);

        run_div(32'hFFFFFFF9, 32'd2,          32'hFFFFFFFD, 32'hFFFFFFFF);
        run_div(32'd7,        32'hFFFFFFFE,   32'hFFFFFFFD, 32'd1);
        run_div(32'hFFFFFFF9, 32'hFFFFFFFE,   32'd3,        32'hFFFFFFFF);
        run_div(32'h242,      32'h10,         32'h24,       32'd2);

        // divide by zero keeps hi/lo
        start(32'h99, 32'h0);
        check("div0_pulse", 32'(dif.div0), 32'h1);
        check("div0_busy", 32'(dif.busy), 32'h0);
        check("div0_done", 32'(dif.done), 32'h0);
        check("div0_hi", dif.hi, 32'd2);
        check("div0_lo", dif.lo, 32'h24);
        @(negedge clk);
        check("div0_clear", 32'(dif.div0), 32'h0);

        run_div(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0);
        run_div(32'h80000000, 32'd1,        32'h80000000, 32'h0);
        run_div(32'd5,        32'd9,        32'h0,        32'd5);

        // start while busy is ignored, then back-to-back start on the done cycle
        start(32'd7, 32'd2);
        repeat (9) @(negedge clk);
        dif.divControl = 1'b1;
        dif.a = 32'd100;
        dif.b = 32'd10;
        @(negedge clk);
        dif.divControl = 1'b0;
        wait_done(ok);
        if (ok) begin
            check("ign_lo", dif.lo, 32'd3);
            check("ign_hi", dif.hi, 32'd1);
            dif.divControl = 1'b1;
            dif.a = 32'd100;
            dif.b = 32'd10;
            @(negedge clk);
            dif.divControl = 1'b0;
            check("b2b_busy", 32'(dif.busy), 32'h1);
            wait_done(ok);
            if (ok) begin
                check("b2b_lo", dif.lo, 32'h0A);
                check("b2b_hi", dif.hi, 32'h0);
            end
        end

        // asynchronous reset mid-run
        start(32'd7, 32'd2);
        repeat (14) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", 32'(dif.busy), 32'h0);
        check("arst_done", 32'(dif.done), 32'h0);
        check("arst_div0", 32'(dif.div0), 32'h0);
        check("arst_hi", dif.hi, 32'h0);
        check("arst_lo", dif.lo, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        run_div(32'd9, 32'd4, 32'd2, 32'd1);
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
